// File: rtl/sdram_arb.sv
// Two-port arbiter that puts video reads and CPU reads/writes onto a single
// asynchronous-strobe SDRAM controller, with round-robin arbitration and fixed access timing.
module sdram_arb #(
  parameter int HOLD_CYCLES = 20,
  parameter int GAP_CYCLES  = 2
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        vid_req,
  input  logic [23:0] vid_addr,
  output logic        vid_ack,
  output logic [15:0] vid_data,
  input  logic        cpu_req,
  input  logic [23:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_be,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [15:0] cpu_rdata,
  output logic [23:0] mem_addr,
  output logic [15:0] mem_din,
  input  logic [15:0] mem_dout,
  output logic        mem_asn,
  output logic        mem_udsn,
  output logic        mem_ldsn,
  output logic        mem_rw
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_DONE, S_GAP} state_t;

  localparam logic [4:0] HOLD_LD = 5'(HOLD_CYCLES - 1);
  localparam logic [4:0] GAP_LD  = 5'(GAP_CYCLES - 1);

  state_t      r_state, w_next;
  logic [4:0]  r_cnt;
  logic        r_gnt_cpu, r_last_cpu, r_we;
  logic [1:0]  r_be;
  logic [23:0] r_addr;
  logic [15:0] r_wdata, r_vid_data, r_cpu_rdata;
  logic        w_any_req, w_pick_cpu, w_cnt_zero;

  assign w_any_req  = vid_req | cpu_req;
  // On a tie the CPU wins only if video was granted last.
  assign w_pick_cpu = cpu_req & (~vid_req | ~r_last_cpu);
  assign w_cnt_zero = (r_cnt == 5'd0);

  assign mem_addr  = r_addr;
  assign mem_din   = r_wdata;
  assign mem_rw    = ~r_we;
  assign vid_data  = r_vid_data;
  assign cpu_rdata = r_cpu_rdata;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next   = r_state;
    mem_asn  = 1'b1;
    mem_udsn = 1'b1;
    mem_ldsn = 1'b1;
    vid_ack  = 1'b0;
    cpu_ack  = 1'b0;
    case (r_state)
      S_IDLE: if (w_any_req) w_next = S_SETUP;
      S_SETUP: begin
        mem_asn = 1'b0;
        w_next  = (r_we && r_be == 2'b00) ? S_DONE : S_STROBE;
      end
      S_STROBE: begin
        mem_asn  = 1'b0;
        mem_udsn = r_we ? ~r_be[1] : 1'b0;
        mem_ldsn = r_we ? ~r_be[0] : 1'b0;
        if (w_cnt_zero) w_next = S_DONE;
      end
      S_DONE: begin
        vid_ack = ~r_gnt_cpu;
        cpu_ack = r_gnt_cpu;
        w_next  = S_GAP;
      end
      S_GAP: if (w_cnt_zero) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= 5'd0;
      r_gnt_cpu   <= 1'b0;
      r_last_cpu  <= 1'b1;
      r_we        <= 1'b0;
      r_be        <= 2'b00;
      r_addr      <= 24'd0;
      r_wdata     <= 16'd0;
      r_vid_data  <= 16'd0;
      r_cpu_rdata <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: if (w_any_req) begin
          r_gnt_cpu  <= w_pick_cpu;
          r_last_cpu <= w_pick_cpu;
          r_addr     <= w_pick_cpu ? cpu_addr : vid_addr;
          r_we       <= w_pick_cpu & cpu_we;
          r_be       <= w_pick_cpu ? cpu_be : 2'b11;
          r_wdata    <= w_pick_cpu ? cpu_wdata : 16'd0;
        end
        S_SETUP: r_cnt <= HOLD_LD;
        S_STROBE: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - 5'd1;
          end else if (!r_we) begin
            if (r_gnt_cpu) r_cpu_rdata <= mem_dout;
            else           r_vid_data  <= mem_dout;
          end
        end
        // GAP_CYCLES must be at least 1 for this reload to mean anything.
        S_DONE: r_cnt <= GAP_LD;
        S_GAP: if (!w_cnt_zero) r_cnt <= r_cnt - 5'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arb.sv
// Directed bench for sdram_arb: a table of single accesses plus hand-written
// sequences for tie arbitration, early request drop and reset during a strobe.
module tb_sdram_arb;

  logic        clk_in = 1'b0;
  logic        rst_n  = 1'b1;
  logic        vid_req = 1'b0;
  logic [23:0] vid_addr = '0;
  logic        vid_ack;
  logic [15:0] vid_data;
  logic        cpu_req = 1'b0;
  logic [23:0] cpu_addr = '0;
  logic        cpu_we = 1'b0;
  logic [1:0]  cpu_be = 2'b00;
  logic [15:0] cpu_wdata = '0;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic [23:0] mem_addr;
  logic [15:0] mem_din;
  logic [15:0] mem_dout = '0;
  logic        mem_asn, mem_udsn, mem_ldsn, mem_rw;

  int total = 0;
  int bad   = 0;

  sdram_arb #(.HOLD_CYCLES(20), .GAP_CYCLES(2)) dut (
    .clk_in(clk_in), .rst_n(rst_n),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_data(vid_data),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_be(cpu_be),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_asn(mem_asn), .mem_udsn(mem_udsn), .mem_ldsn(mem_ldsn), .mem_rw(mem_rw)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        is_cpu;
    logic        we;
    logic [1:0]  be;
    logic [23:0] addr;
    logic [15:0] wdata;
    logic [15:0] dout;
    int          exp_lat;
    int          exp_asn;
    int          exp_uds;
    int          exp_lds;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [7];

  task automatic run_vec(input vec_t v, input int idx);
    int   cyc, lat, asn_n, uds_n, lds_n, other, extra;
    logic bus_ok, exp_rw, own, oth;
    exp_rw = !(v.is_cpu && v.we);
    mem_dout = v.dout;
    if (v.is_cpu) begin
      cpu_req = 1'b1; cpu_addr = v.addr; cpu_we = v.we; cpu_be = v.be; cpu_wdata = v.wdata;
    end else begin
      vid_req = 1'b1; vid_addr = v.addr;
    end
    cyc = 0; lat = -1; asn_n = 0; uds_n = 0; lds_n = 0; other = 0; extra = 0; bus_ok = 1'b1;
    while (lat < 0 && cyc < 100) begin
      @(negedge clk_in);
      cyc++;
      own = v.is_cpu ? cpu_ack : vid_ack;
      oth = v.is_cpu ? vid_ack : cpu_ack;
      if (!mem_asn) asn_n++;
      if (!mem_udsn) uds_n++;
      if (!mem_ldsn) lds_n++;
      if (oth) other++;
      if (!mem_asn || own) begin
        if (mem_addr !== v.addr || mem_rw !== exp_rw || (!exp_rw && mem_din !== v.wdata))
          bus_ok = 1'b0;
      end
      if (own) begin
        lat = cyc;
        vid_req = 1'b0;
        cpu_req = 1'b0;
      end
    end
    vid_req = 1'b0;
    cpu_req = 1'b0;
    check($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    check($sformatf("v%0d_asn_low", idx), asn_n, v.exp_asn);
    check($sformatf("v%0d_udsn_low", idx), uds_n, v.exp_uds);
    check($sformatf("v%0d_ldsn_low", idx), lds_n, v.exp_lds);
    check($sformatf("v%0d_bus_stable", idx), {31'd0, bus_ok}, 32'd1);
    check($sformatf("v%0d_rdata", idx), v.is_cpu ? cpu_rdata : vid_data, v.exp_rdata);
    repeat (4) begin
      @(negedge clk_in);
      if (vid_ack || cpu_ack) extra++;
    end
    check($sformatf("v%0d_stray_ack", idx), other + extra, 0);
  endtask

  initial begin
    int   cyc, lat, n, hi_run, min_gap, acks_in_rst;
    logic seen_low;
    logic order [4];
    int   t [4];

    vecs[0] = '{1'b0, 1'b0, 2'b11, 24'h000123, 16'h0000, 16'hBEEF, 22, 21, 20, 20, 16'hBEEF};
    vecs[1] = '{1'b1, 1'b1, 2'b10, 24'h400000, 16'h1234, 16'hFFFF, 22, 21, 20,  0, 16'h0000};
    vecs[2] = '{1'b1, 1'b0, 2'b11, 24'h000010, 16'h0000, 16'h5A5A, 22, 21, 20, 20, 16'h5A5A};
    vecs[3] = '{1'b1, 1'b1, 2'b01, 24'h7FFFFF, 16'hABCD, 16'hFFFF, 22, 21,  0, 20, 16'h5A5A};
    vecs[4] = '{1'b1, 1'b1, 2'b00, 24'h000555, 16'h9999, 16'hFFFF,  2,  1,  0,  0, 16'h5A5A};
    vecs[5] = '{1'b1, 1'b0, 2'b01, 24'h000020, 16'h0000, 16'h1357, 22, 21, 20, 20, 16'h1357};
    vecs[6] = '{1'b0, 1'b0, 2'b11, 24'hFFFFFF, 16'h0000, 16'hC0DE, 22, 21, 20, 20, 16'hC0DE};

    // Reset values must appear before any clock edge.
    #1 rst_n = 1'b0;
    #2;
    check("reset_strobes", {28'd0, mem_asn, mem_udsn, mem_ldsn, mem_rw}, 32'hF);
    check("reset_addr", mem_addr, 0);
    check("reset_din", mem_din, 0);
    check("reset_acks", {30'd0, vid_ack, cpu_ack}, 0);
    check("reset_rdata", {vid_data, cpu_rdata}, 0);
    repeat (3) @(negedge clk_in);
    rst_n = 1'b1;

    // First vector requests in the same half-cycle as reset release.
    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Requester drops req early; access and ack still complete.
    mem_dout = 16'h0F0F;
    cpu_req = 1'b1; cpu_addr = 24'h000300; cpu_we = 1'b0; cpu_be = 2'b11;
    cyc = 0; lat = -1;
    while (lat < 0 && cyc < 100) begin
      @(negedge clk_in);
      cyc++;
      if (cyc == 5) cpu_req = 1'b0;
      if (cpu_ack) lat = cyc;
    end
    check("drop_latency", lat, 22);
    check("drop_rdata", cpu_rdata, 16'h0F0F);
    repeat (4) @(negedge clk_in);

    // Reset in the middle of a strobe, then the still-pending request completes.
    mem_dout = 16'h2468;
    cpu_req = 1'b1; cpu_addr = 24'h000200; cpu_we = 1'b0; cpu_be = 2'b11;
    repeat (10) @(negedge clk_in);
    check("pre_reset_in_strobe", {31'd0, mem_udsn}, 0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_strobes_high", {29'd0, mem_asn, mem_udsn, mem_ldsn}, 32'h7);
    acks_in_rst = 0;
    repeat (3) begin
      @(negedge clk_in);
      if (vid_ack || cpu_ack) acks_in_rst++;
    end
    check("rst_no_ack", acks_in_rst, 0);
    check("rst_rdata_cleared", cpu_rdata, 0);
    rst_n = 1'b1;
    cyc = 0; lat = -1;
    while (lat < 0 && cyc < 100) begin
      @(negedge clk_in);
      cyc++;
      if (cpu_ack) begin
        lat = cyc;
        cpu_req = 1'b0;
      end
    end
    cpu_req = 1'b0;
    check("post_rst_latency", lat, 22);
    check("post_rst_rdata", cpu_rdata, 16'h2468);
    repeat (4) @(negedge clk_in);

    // Fresh reset, then both ports request continuously: video wins the first tie.
    rst_n = 1'b0;
    @(negedge clk_in);
    rst_n = 1'b1;
    mem_dout = 16'h1111;
    vid_req = 1'b1; vid_addr = 24'h000A00;
    cpu_req = 1'b1; cpu_addr = 24'h000B00; cpu_we = 1'b0; cpu_be = 2'b11;
    cyc = 0; n = 0; hi_run = 0; min_gap = 1000; seen_low = 1'b0;
    while (n < 4 && cyc < 300) begin
      @(negedge clk_in);
      cyc++;
      if (!mem_asn) begin
        if (seen_low && hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
        hi_run = 0;
        seen_low = 1'b1;
      end else begin
        hi_run++;
      end
      if (vid_ack || cpu_ack) begin
        order[n] = cpu_ack;
        t[n] = cyc;
        n++;
      end
    end
    vid_req = 1'b0;
    cpu_req = 1'b0;
    check("tie_ack_count", n, 4);
    if (n == 4) begin
      check("tie_first_time", t[0], 22);
      check("tie_order", {28'd0, order[0], order[1], order[2], order[3]}, 32'b0101);
      for (int k = 1; k < 4; k++)
        check($sformatf("tie_spacing_%0d", k), t[k] - t[k-1], 25);
      check("tie_strobe_gap", min_gap, 4);
    end
    repeat (4) @(negedge clk_in);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
